instr_fetch_decode: RTL and testbench
=====================================

Name: instr_fetch_decode

Overview:
- Front end of the simple processor; sits directly downstream of the program ROM (16-bit words, 8-bit address, registered read, 1-cycle latency).
- Owns the PC, issues ROM reads and captures each returned word in an instruction register.
- Splits the word into opcode/register/immediate fields and presents one decoded instruction at a time to the execute stage with a valid/ready handshake.
- Takes branch redirects from execute and stops fetching on HALT.

Parameters:
- M, 16: instruction width; fields fixed at [15:12] opcode, [11:8] dst reg, [7:4] src reg, [7:0] imm.
- N, 8: PC / ROM address width.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin fetching from PC=0; sampled only in IDLE.
- rom_rd  out  1  ROM read enable.
- rom_addr  out  N  ROM address (= PC).
- rom_data  in  M  ROM word, valid the cycle after rom_rd.
- instr_valid  out  1  decoded instruction available.
- ex_ready  in  1  execute accepts instruction when instr_valid & ex_ready.
- opcode  out  4  IR[15:12].
- dst_reg  out  4  IR[11:8].
- src_reg  out  4  IR[7:4].
- imm  out  8  IR[7:0].
- instr_pc  out  N  address the presented instruction was fetched from.
- br_taken  in  1  redirect; valid only in the accept cycle.
- br_target  in  N  redirect target PC.
- halted  out  1  HALT fetched; fetching stopped.
- illegal  out  1  sticky undefined-opcode flag (see optional feature).

Behaviour:
- Reset (async, rst_n low): state=IDLE, PC=0, IR=0; rom_rd, instr_valid, halted and illegal=0; rom_addr=0; all field outputs 0.
- Field outputs are driven from IR at all times and are meaningful only while instr_valid=1.
- Defined opcodes:
  - 0010 MOV reg,reg; 0011 MOV reg,#imm; 0100 ADD; 0101 SUB.
  - 0110 JZ reg,target; 0111 RL reg,#imm; 1000 MOV mem,reg; 1111 HALT.
  - All others are undefined.
- FSM states: IDLE, FETCH, WAIT, PRESENT, HALT.
- IDLE: outputs quiet. start=1 -> FETCH next cycle.
- FETCH: rom_rd=1, rom_addr=PC for exactly one cycle -> WAIT.
- WAIT: rom_rd=0. Capture rom_data into IR at end of cycle; instr_pc<=PC; PC<=PC+1 (mod 2^N; 255 wraps to 0 silently).
  - Next state PRESENT if opcode defined and not 1111.
  - HALT if opcode 1111.
  - Undefined opcode: per optional feature.
- PRESENT: instr_valid=1; IR and fields stable while ex_ready=0 (no change for any number of stall cycles).
  - On accept with br_taken=1: PC<=br_target, -> FETCH.
  - On accept with br_taken=0: PC unchanged, -> FETCH.
  - br_taken is ignored when there is no accept.
- Throughput: one instruction per 3 cycles with ex_ready tied high (FETCH, WAIT, PRESENT).
- First rom_rd occurs the cycle after start is sampled. First instr_valid occurs 2 cycles after rom_rd.
- HALT: halted=1, rom_rd=0, instr_valid=0. HALT is never presented to execute. Exit only via rst_n.
- Reset mid-operation: immediate return to reset values, including in WAIT with a read outstanding; the stale ROM word is never captured.
- start is ignored outside IDLE.

Optional Feature:
- Macro: IFD_ILLEGAL_TRAP_EN.
- Defined: an undefined opcode captured in WAIT sets illegal=1 (sticky until reset) and -> HALT with halted=1. The word is not presented.
- Undefined: an undefined opcode is treated as NOP. It is skipped (-> FETCH of PC+1) and never presented; the illegal output is tied to 0.

Test Plan:
- Reset, hold start=0 for 5 cycles -> rom_rd=0, instr_valid=0, halted=0, rom_addr=0 throughout.
- ROM model with word0=0x3000, word1=0x310A; pulse start, ex_ready=1 -> rom_rd at addr 0, then instr_valid with opcode=3, dst_reg=0, imm=0x00, instr_pc=0. Three cycles later: opcode=3, dst_reg=1, imm=0x0A, instr_pc=1.
- Hold ex_ready=0 for 10 cycles while word 0x4010 is presented -> instr_valid stays 1, fields constant, no rom_rd. Raise ex_ready -> next rom_rd at addr+1.
- Accept 0x6308 (JZ) with br_taken=1, br_target=4 -> next rom_addr=4, and instr_pc of the next instruction=4.
- Word 0xF00B at addr 11 -> halted=1 two cycles after its rom_rd, instr_valid never asserted for it, no further rom_rd for 20 cycles. Pulse rst_n low -> halted=0.
- PC wrap: branch to 255 holding 0x3000 -> next fetch addr=0. Place 0x9000 at addr 5 -> with IFD_ILLEGAL_TRAP_EN: illegal=1, halted=1; without it: skipped, next rom_addr=6.

Source files
------------

// File: rtl/instr_fetch_decode.sv
// Instruction fetch/decode front end.
// Owns the PC, reads the program ROM (registered read, 1-cycle latency), holds
// the returned word in an instruction register and presents its decoded fields
// to execute over a valid/ready handshake. Handles branch redirects and HALT.
//
// Build option: define IFD_ILLEGAL_TRAP_EN to trap on undefined opcodes (sticky
// illegal flag, fetch stops). Without it, undefined opcodes are skipped as NOPs
// and the illegal output is tied low.

module instr_fetch_decode #(
    parameter int unsigned M = 16,
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic         rom_rd,
    output logic [N-1:0] rom_addr,
    input  logic [M-1:0] rom_data,
    output logic         instr_valid,
    input  logic         ex_ready,
    output logic [3:0]   opcode,
    output logic [3:0]   dst_reg,
    output logic [3:0]   src_reg,
    output logic [7:0]   imm,
    output logic [N-1:0] instr_pc,
    input  logic         br_taken,
    input  logic [N-1:0] br_target,
    output logic         halted,
    output logic         illegal
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StPresent,
        StHalt
    } state_e;

    localparam logic [3:0] OpMovRr  = 4'b0010;
    localparam logic [3:0] OpMovRi  = 4'b0011;
    localparam logic [3:0] OpAdd    = 4'b0100;
    localparam logic [3:0] OpSub    = 4'b0101;
    localparam logic [3:0] OpJz     = 4'b0110;
    localparam logic [3:0] OpRl     = 4'b0111;
    localparam logic [3:0] OpMovMr  = 4'b1000;
    localparam logic [3:0] OpHalt   = 4'b1111;

    state_e         state_q, state_d;
    logic [N-1:0]   pc_q, pc_d;
    logic [M-1:0]   ir_q, ir_d;
    logic [N-1:0]   instr_pc_q, instr_pc_d;
    logic [3:0]     fetched_op;

    // True for every opcode the execute stage understands (HALT included).
    function automatic logic opcode_defined(input logic [3:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            OpMovRr, OpMovRi, OpAdd, OpSub,
            OpJz, OpRl, OpMovMr, OpHalt: ok = 1'b1;
            default:                     ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Opcode of the word arriving from the ROM (only meaningful in WAIT).
    assign fetched_op = rom_data[15:12];

`ifdef IFD_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
`endif

    // State, PC, IR and fetch-address registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            pc_q       <= '0;
            ir_q       <= '0;
            instr_pc_q <= '0;
`ifdef IFD_ILLEGAL_TRAP_EN
            illegal_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            instr_pc_q <= instr_pc_d;
`ifdef IFD_ILLEGAL_TRAP_EN
            illegal_q  <= illegal_d;
`endif
        end
    end

    // Next-state logic: fetch sequencing, IR capture, decode and redirects.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        instr_pc_d = instr_pc_q;
`ifdef IFD_ILLEGAL_TRAP_EN
        illegal_d  = illegal_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                state_d = StWait;
            end
            StWait: begin
                // ROM word is valid this cycle; the PC wraps modulo 2^N.
                ir_d       = rom_data;
                instr_pc_d = pc_q;
                pc_d       = pc_q + N'(1);
                if (fetched_op == OpHalt) begin
                    state_d = StHalt;
                end else if (opcode_defined(fetched_op)) begin
                    state_d = StPresent;
                end else begin
`ifdef IFD_ILLEGAL_TRAP_EN
                    illegal_d = 1'b1;
                    state_d   = StHalt;
`else
                    // Undefined opcode behaves as NOP: never presented.
                    state_d   = StFetch;
`endif
                end
            end
            StPresent: begin
                // br_taken only matters in the accept cycle.
                if (ex_ready) begin
                    if (br_taken) begin
                        pc_d = br_target;
                    end
                    state_d = StFetch;
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign rom_rd      = (state_q == StFetch);
    assign rom_addr    = pc_q;
    assign instr_valid = (state_q == StPresent);
    assign halted      = (state_q == StHalt);

    // Fields come straight from the IR, so they hold steady through stalls.
    assign opcode   = ir_q[15:12];
    assign dst_reg  = ir_q[11:8];
    assign src_reg  = ir_q[7:4];
    assign imm      = ir_q[7:0];
    assign instr_pc = instr_pc_q;

`ifdef IFD_ILLEGAL_TRAP_EN
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed bench for instr_fetch_decode with a registered-read ROM model and a
// scoreboard of expected presented instructions.

module tb_instr_fetch_decode;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        rom_rd;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        instr_valid;
    logic        ex_ready;
    logic [3:0]  opcode;
    logic [3:0]  dst_reg;
    logic [3:0]  src_reg;
    logic [7:0]  imm;
    logic [7:0]  instr_pc;
    logic        br_taken;
    logic [7:0]  br_target;
    logic        halted;
    logic        illegal;

    instr_fetch_decode #(
        .M(16),
        .N(8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .rom_rd     (rom_rd),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .instr_valid(instr_valid),
        .ex_ready   (ex_ready),
        .opcode     (opcode),
        .dst_reg    (dst_reg),
        .src_reg    (src_reg),
        .imm        (imm),
        .instr_pc   (instr_pc),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .halted     (halted),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: registered read, data valid the cycle after rom_rd.
    logic [15:0] rom_mem [256];
    logic [15:0] rom_q;
    always @(posedge clk) begin
        if (rom_rd) rom_q <= rom_mem[rom_addr];
    end
    assign rom_data = rom_q;

    typedef struct packed {
        logic [7:0]  pc;
        logic [15:0] word;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Called in a FETCH cycle; leaves the bench two cycles later.
    task automatic expect_fetch(input logic [7:0] addr, input bit push);
        exp_t e;
        check("fetch_rd", 32'(rom_rd), 1);
        check("fetch_addr", 32'(rom_addr), 32'(addr));
        check("fetch_nvalid", 32'(instr_valid), 0);
        if (push) begin
            e.pc   = addr;
            e.word = rom_mem[addr];
            sb.push_back(e);
        end
        step();
        check("wait_rd", 32'(rom_rd), 0);
        check("wait_nvalid", 32'(instr_valid), 0);
        step();
    endtask

    // Checks the presented instruction, stalls, then accepts with given redirect.
    task automatic present(input int stall, input logic br, input logic [7:0] tgt);
        exp_t e;
        check("sb_depth", 32'(sb.size()), 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check("valid", 32'(instr_valid), 1);
        check("opcode", 32'(opcode), 32'(e.word[15:12]));
        check("dst_reg", 32'(dst_reg), 32'(e.word[11:8]));
        check("src_reg", 32'(src_reg), 32'(e.word[7:4]));
        check("imm", 32'(imm), 32'(e.word[7:0]));
        check("instr_pc", 32'(instr_pc), 32'(e.pc));
        for (int i = 0; i < stall; i++) begin
            ex_ready  = 1'b0;
            br_taken  = 1'b1;
            br_target = 8'h20;
            step();
            check("stall_valid", 32'(instr_valid), 1);
            check("stall_rd", 32'(rom_rd), 0);
            check("stall_fields", 32'({opcode, dst_reg, src_reg, imm[3:0]}), 32'(e.word));
            check("stall_pc", 32'(instr_pc), 32'(e.pc));
        end
        ex_ready  = 1'b1;
        br_taken  = br;
        br_target = tgt;
        step();
        ex_ready  = 1'b0;
        br_taken  = 1'b0;
        br_target = 8'h00;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_rd"}, 32'(rom_rd), 0);
        check({tag, "_valid"}, 32'(instr_valid), 0);
        check({tag, "_halted"}, 32'(halted), 0);
        check({tag, "_addr"}, 32'(rom_addr), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd_cnt;
        int val_cnt;
        for (int i = 0; i < 256; i++) rom_mem[i] = 16'h0000;
        rom_mem[0]   = 16'h3000;
        rom_mem[1]   = 16'h310A;
        rom_mem[2]   = 16'h4010;
        rom_mem[3]   = 16'h6308;
        rom_mem[4]   = 16'h6308;
        rom_mem[5]   = 16'h9000;
        rom_mem[6]   = 16'h7304;
        rom_mem[9]   = 16'h2120;
        rom_mem[10]  = 16'h5230;
        rom_mem[11]  = 16'hF00B;
        rom_mem[255] = 16'h3000;
        rom_q     = 16'h0000;
        rst_n     = 1'b1;
        start     = 1'b0;
        ex_ready  = 1'b0;
        br_taken  = 1'b0;
        br_target = 8'h00;

        // Reset values.
        #2 rst_n = 1'b0;
        step();
        step();
        check_quiet("rst");
        check("rst_illegal", 32'(illegal), 0);
        check("rst_ir", 32'({opcode, dst_reg, src_reg, imm}), 0);
        check("rst_instr_pc", 32'(instr_pc), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_quiet("idle");
        end

        // Sequential fetch, stall, branches and HALT.
        start = 1'b1;
        step();
        start = 1'b0;
        expect_fetch(8'd0, 1'b1);
        present(0, 1'b0, 8'h00);
        expect_fetch(8'd1, 1'b1);
        present(0, 1'b0, 8'h00);
        expect_fetch(8'd2, 1'b1);
        present(10, 1'b0, 8'h00);
        expect_fetch(8'd3, 1'b1);
        present(0, 1'b1, 8'd4);
        expect_fetch(8'd4, 1'b1);
        present(0, 1'b1, 8'd9);
        expect_fetch(8'd9, 1'b1);
        present(0, 1'b0, 8'h00);
        expect_fetch(8'd10, 1'b1);
        present(0, 1'b1, 8'd11);
        expect_fetch(8'd11, 1'b0);
        check("halt_halted", 32'(halted), 1);
        check("halt_nvalid", 32'(instr_valid), 0);
        check("halt_illegal", 32'(illegal), 0);
        rd_cnt  = 0;
        val_cnt = 0;
        start   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (rom_rd) rd_cnt++;
            if (instr_valid) val_cnt++;
        end
        start = 1'b0;
        check("halt_no_rd", 32'(rd_cnt), 0);
        check("halt_no_valid", 32'(val_cnt), 0);
        check("halt_stays", 32'(halted), 1);
        rst_n = 1'b0;
        #1;
        check("halt_rst_halted", 32'(halted), 0);
        check("halt_rst_addr", 32'(rom_addr), 0);
        check("halt_rst_ir", 32'({opcode, dst_reg, src_reg, imm}), 0);
        step();
        rst_n = 1'b1;
        step();

        // PC wrap and undefined opcode.
        start = 1'b1;
        step();
        start = 1'b0;
        expect_fetch(8'd0, 1'b1);
        present(0, 1'b1, 8'd255);
        expect_fetch(8'd255, 1'b1);
        present(0, 1'b0, 8'h00);
        expect_fetch(8'd0, 1'b1);
        present(0, 1'b1, 8'd5);
        expect_fetch(8'd5, 1'b0);
`ifdef IFD_ILLEGAL_TRAP_EN
        check("trap_illegal", 32'(illegal), 1);
        check("trap_halted", 32'(halted), 1);
        check("trap_nvalid", 32'(instr_valid), 0);
        step();
        step();
        step();
        check("trap_sticky", 32'(illegal), 1);
        check("trap_no_rd", 32'(rom_rd), 0);
`else
        check("nop_illegal", 32'(illegal), 0);
        check("nop_halted", 32'(halted), 0);
        expect_fetch(8'd6, 1'b1);
        present(0, 1'b0, 8'h00);
        check("nop_illegal_after", 32'(illegal), 0);
`endif
        rst_n = 1'b0;
        #1;
        check("ill_rst_illegal", 32'(illegal), 0);
        check("ill_rst_halted", 32'(halted), 0);
        step();
        rst_n = 1'b1;
        step();

        // Reset with a read outstanding: the stale word must not land in the IR.
        start = 1'b1;
        step();
        start = 1'b0;
        check("midrst_rd", 32'(rom_rd), 1);
        step();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_rd_off", 32'(rom_rd), 0);
        check("midrst_ir", 32'({opcode, dst_reg, src_reg, imm}), 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        check("midrst_ir_after", 32'({opcode, dst_reg, src_reg, imm}), 0);
        check("midrst_nvalid", 32'(instr_valid), 0);
        check("midrst_idle_rd", 32'(rom_rd), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
